// File: rtl/divisor_param_secuencial_if.sv
`default_nettype none
// =====================================================================
// divisor_param_secuencial_if : go/done operand and result bundle
// Rev 1.0
// =====================================================================
interface divisor_param_secuencial_if #(
    parameter int DD_W = 32,
    parameter int DV_W = 16
);
    logic            inicie;
    logic            con_signo;
    logic [DD_W-1:0] dividendo;
    logic [DV_W-1:0] divisor;
    logic [DD_W-1:0] cociente;
    logic [DV_W-1:0] residuo;
    logic            div_cero;
    logic            desborde;
    logic            termino;

    modport master (
        output inicie, con_signo, dividendo, divisor,
        input  cociente, residuo, div_cero, desborde, termino
    );

    modport slave (
        input  inicie, con_signo, dividendo, divisor,
        output cociente, residuo, div_cero, desborde, termino
    );
endinterface
`default_nettype wire

// File: rtl/divisor_param_secuencial.sv
`default_nettype none
// =====================================================================
// divisor_param_secuencial : iterative restoring divider, BPC bits/clock
// Rev 1.0
// =====================================================================
module divisor_param_secuencial #(
    parameter int DD_W = 32,
    parameter int DV_W = 16,
    parameter int BPC  = 1
) (
    input wire                        reloj,
    input wire                        reset,
    divisor_param_secuencial_if.slave bus
);
    localparam int              c_N      = DD_W / BPC;
    localparam int              c_CW     = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_ULT    = c_CW'(c_N - 1);
    localparam logic [DD_W-1:0] c_DD_MIN = {1'b1, {(DD_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        CALC   = 2'd1,
        AJUSTE = 2'd2
    } estado_t;

    estado_t         r_estado;
    logic [c_CW-1:0] r_cnt;
    logic [DD_W-1:0] r_quo;
    logic [DV_W-1:0] r_rem;
    logic [DV_W-1:0] r_dv;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_cero;
    logic            r_desb;
    logic [DD_W-1:0] r_cociente;
    logic [DV_W-1:0] r_residuo;
    logic            r_div_cero;
    logic            r_desborde;
    logic            r_termino;

    logic            w_sdd;
    logic            w_sdv;
    logic [DD_W-1:0] w_dd_mag;
    logic [DV_W-1:0] w_dv_mag;
    logic [DV_W:0]   w_rem;
    logic [DV_W:0]   w_trial;
    logic [DD_W-1:0] w_quo;
    logic [DD_W-1:0] w_q_fin;
    logic [DV_W-1:0] w_r_fin;

    // Magnitudes are taken unsigned at full width so the most negative value maps cleanly.
    assign w_sdd    = bus.con_signo & bus.dividendo[DD_W-1];
    assign w_sdv    = bus.con_signo & bus.divisor[DV_W-1];
    assign w_dd_mag = w_sdd ? (~bus.dividendo + 1'b1) : bus.dividendo;
    assign w_dv_mag = w_sdv ? (~bus.divisor + 1'b1)   : bus.divisor;

    // Partial remainder stays below the divisor, so one extra bit makes the trial subtraction safe.
    always_comb begin
        w_rem   = {1'b0, r_rem};
        w_quo   = r_quo;
        w_trial = '0;
        for (int i = 0; i < BPC; i++) begin
            w_rem   = {w_rem[DV_W-1:0], w_quo[DD_W-1]};
            w_quo   = {w_quo[DD_W-2:0], 1'b0};
            w_trial = w_rem - {1'b0, r_dv};
            if (!w_trial[DV_W]) begin
                w_rem    = w_trial;
                w_quo[0] = 1'b1;
            end
        end
    end

    assign w_q_fin = r_cero ? '1 : (r_neg_q ? (~r_quo + 1'b1) : r_quo);
    assign w_r_fin = r_cero ? '0 : (r_neg_r ? (~r_rem + 1'b1) : r_rem);

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            r_estado   <= ESPERA;
            r_cnt      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dv       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_cero     <= 1'b0;
            r_desb     <= 1'b0;
            r_cociente <= '0;
            r_residuo  <= '0;
            r_div_cero <= 1'b0;
            r_desborde <= 1'b0;
            r_termino  <= 1'b1;
        end else begin
            case (r_estado)
                ESPERA: begin
                    if (bus.inicie) begin
                        r_quo     <= w_dd_mag;
                        r_dv      <= w_dv_mag;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_neg_q   <= w_sdd ^ w_sdv;
                        r_neg_r   <= w_sdd;
                        r_cero    <= (bus.divisor == '0);
                        r_desb    <= bus.con_signo && (bus.dividendo == c_DD_MIN)
                                     && (bus.divisor == '1);
                        r_termino <= 1'b0;
                        r_estado  <= CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_rem[DV_W-1:0];
                    r_quo <= w_quo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_ULT) begin
                        r_estado <= AJUSTE;
                    end
                end
                AJUSTE: begin
                    r_cociente <= w_q_fin;
                    r_residuo  <= w_r_fin;
                    r_div_cero <= r_cero;
                    r_desborde <= r_desb;
                    r_termino  <= 1'b1;
                    r_estado   <= ESPERA;
                end
                default: begin
                    r_termino <= 1'b1;
                    r_estado  <= ESPERA;
                end
            endcase
        end
    end

    assign bus.cociente = r_cociente;
    assign bus.residuo  = r_residuo;
    assign bus.div_cero = r_div_cero;
    assign bus.desborde = r_desborde;
    assign bus.termino  = r_termino;
endmodule
`default_nettype wire

// File: tb/tb_divisor_param_secuencial.sv
`default_nettype none
// =====================================================================
// tb_divisor_param_secuencial : scoreboard bench for BPC=1 and BPC=4
// Rev 1.0
// =====================================================================
module tb_divisor_param_secuencial;
    logic reloj = 1'b0;
    logic reset = 1'b0;
    always #5 reloj = ~reloj;

    divisor_param_secuencial_if #(.DD_W(32), .DV_W(16)) ifc1 ();
    divisor_param_secuencial_if #(.DD_W(32), .DV_W(16)) ifc4 ();

    divisor_param_secuencial #(.DD_W(32), .DV_W(16), .BPC(1)) dut1 (
        .reloj(reloj), .reset(reset), .bus(ifc1));
    divisor_param_secuencial #(.DD_W(32), .DV_W(16), .BPC(4)) dut4 (
        .reloj(reloj), .reset(reset), .bus(ifc4));

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        string       nm;
    } exp_t;

    typedef struct {
        logic        sg;
        logic [31:0] dd;
        logic [15:0] dv;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        string       nm;
    } vec_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   nchk = 0;
    int   nerr = 0;
    int   ncyc = 0;

    task automatic chk(string nm, int sel, logic [63:0] act, logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, sel, act, req);
        end
    endtask

    task automatic drive(int sel, logic ini, logic sg, logic [31:0] dd, logic [15:0] dv);
        if (sel == 0) begin
            ifc1.inicie = ini; ifc1.con_signo = sg; ifc1.dividendo = dd; ifc1.divisor = dv;
        end else begin
            ifc4.inicie = ini; ifc4.con_signo = sg; ifc4.dividendo = dd; ifc4.divisor = dv;
        end
    endtask

    function automatic logic get_t(int sel);
        return (sel == 0) ? ifc1.termino : ifc4.termino;
    endfunction

    task automatic push(int sel, logic [31:0] q, logic [15:0] r, logic dz, logic ov, string nm);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.nm = nm;
        if (sel == 0) sb0.push_back(e);
        else          sb1.push_back(e);
    endtask

    task automatic wait_done(int sel);
        int n = 0;
        while (get_t(sel) !== 1'b1 && n < 200) begin
            @(negedge reloj);
            n++;
        end
        if (n >= 200) chk("timeout_termino", sel, 64'd0, 64'd1);
    endtask

    // Operands are scrambled once accepted; the result must come from the captured copy.
    task automatic run_op(int sel, vec_t v);
        push(sel, v.q, v.r, v.dz, v.ov, v.nm);
        @(posedge reloj); #2;
        drive(sel, 1'b1, v.sg, v.dd, v.dv);
        @(posedge reloj); #2;
        drive(sel, 1'b0, ~v.sg, ~v.dd, ~v.dv);
        wait_done(sel);
    endtask

    task automatic chk_reset(int sel, string nm);
        if (sel == 0) begin
            chk({nm, "_termino"}, 0, ifc1.termino, 1);
            chk({nm, "_cociente"}, 0, ifc1.cociente, 0);
            chk({nm, "_residuo"}, 0, ifc1.residuo, 0);
            chk({nm, "_div_cero"}, 0, ifc1.div_cero, 0);
            chk({nm, "_desborde"}, 0, ifc1.desborde, 0);
        end else begin
            chk({nm, "_termino"}, 1, ifc4.termino, 1);
            chk({nm, "_cociente"}, 1, ifc4.cociente, 0);
            chk({nm, "_residuo"}, 1, ifc4.residuo, 0);
            chk({nm, "_div_cero"}, 1, ifc4.div_cero, 0);
            chk({nm, "_desborde"}, 1, ifc4.desborde, 0);
        end
    endtask

    initial forever begin
        @(posedge reloj);
        ncyc++;
    end

    // Monitor: detects acceptance and completion per DUT, checks latency and pops results.
    initial begin
        logic        pt[2];
        logic        pi[2];
        int          acc[2];
        bit          accv[2];
        logic        t, ini, dz, ov;
        logic [31:0] q;
        logic [15:0] r;
        exp_t        e;
        bit          have;
        for (int d = 0; d < 2; d++) begin
            pt[d] = 1'b1; pi[d] = 1'b0; acc[d] = 0; accv[d] = 1'b0;
        end
        forever begin
            @(negedge reloj);
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    t = ifc1.termino; ini = ifc1.inicie; q = ifc1.cociente;
                    r = ifc1.residuo; dz = ifc1.div_cero; ov = ifc1.desborde;
                end else begin
                    t = ifc4.termino; ini = ifc4.inicie; q = ifc4.cociente;
                    r = ifc4.residuo; dz = ifc4.div_cero; ov = ifc4.desborde;
                end
                if (!reset) begin
                    pt[d] = t; pi[d] = 1'b0; accv[d] = 1'b0;
                end else begin
                    if (pt[d] && pi[d]) begin
                        chk("termino_cae", d, t, 0);
                        acc[d]  = ncyc;
                        accv[d] = 1'b1;
                    end else if (!pt[d] && t) begin
                        if (accv[d]) chk("latencia", d, ncyc - acc[d], (d == 0) ? 33 : 9);
                        else         chk("aceptacion_vista", d, 0, 1);
                        accv[d] = 1'b0;
                        have = 1'b0;
                        if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
                        if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
                        if (!have) begin
                            chk("resultado_inesperado", d, 1, 0);
                        end else begin
                            chk({e.nm, "_cociente"}, d, q, e.q);
                            chk({e.nm, "_residuo"}, d, r, e.r);
                            chk({e.nm, "_div_cero"}, d, dz, e.dz);
                            chk({e.nm, "_desborde"}, d, ov, e.ov);
                        end
                    end
                    pt[d] = t;
                    pi[d] = ini;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tab[9];
        vec_t va, vb;
        tab[0] = '{1'b0, 32'h0000_0352, 16'h0003, 32'h0000_011B, 16'h0001, 1'b0, 1'b0, "u_352_3"};
        tab[1] = '{1'b0, 32'hFFFF_F1FD, 16'hFFF0, 32'h0001_000F, 16'hF2ED, 1'b0, 1'b0, "u_big"};
        tab[2] = '{1'b1, 32'hFFFF_F1FD, 16'hFFF0, 32'h0000_00E0, 16'hFFFD, 1'b0, 1'b0, "s_big"};
        tab[3] = '{1'b1, 32'hFFFF_FF24, 16'h0021, 32'hFFFF_FFFA, 16'hFFEA, 1'b0, 1'b0, "s_neg_pos"};
        tab[4] = '{1'b0, 32'd1024,      16'h0020, 32'h0000_0020, 16'h0000, 1'b0, 1'b0, "u_exacta"};
        tab[5] = '{1'b0, 32'd100,       16'h0000, 32'hFFFF_FFFF, 16'h0000, 1'b1, 1'b0, "u_div0"};
        tab[6] = '{1'b1, 32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'h0000, 1'b0, 1'b1, "s_desborde"};
        tab[7] = '{1'b1, 32'd7,         16'hFFFE, 32'hFFFF_FFFD, 16'h0001, 1'b0, 1'b0, "s_7_m2"};
        tab[8] = '{1'b1, 32'hFFFF_FFF9, 16'h0002, 32'hFFFF_FFFD, 16'hFFFF, 1'b0, 1'b0, "s_m7_2"};
        va = tab[0];
        vb = tab[3];

        drive(0, 1'b0, 1'b0, 32'd0, 16'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 16'd0);
        #12;
        chk_reset(0, "reset_inicial");
        chk_reset(1, "reset_inicial");
        @(posedge reloj); #2;
        reset = 1'b1;

        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 9; i++) run_op(sel, tab[i]);

            // inicie held high: second operation must start on the first idle edge.
            push(sel, va.q, va.r, va.dz, va.ov, "b2b_a");
            push(sel, vb.q, vb.r, vb.dz, vb.ov, "b2b_b");
            @(posedge reloj); #2;
            drive(sel, 1'b1, va.sg, va.dd, va.dv);
            @(posedge reloj); #2;
            drive(sel, 1'b1, vb.sg, vb.dd, vb.dv);
            wait_done(sel);
            @(posedge reloj); #2;
            drive(sel, 1'b0, 1'b0, 32'd0, 16'd0);
            wait_done(sel);

            // Abort mid-calculation with an asynchronous reset pulse.
            @(posedge reloj); #2;
            drive(sel, 1'b1, va.sg, va.dd, va.dv);
            @(posedge reloj); #2;
            drive(sel, 1'b0, 1'b0, 32'd0, 16'd0);
            repeat ((sel == 0) ? 10 : 5) @(posedge reloj);
            #2;
            reset = 1'b0;
            #1;
            chk_reset(sel, "reset_abort");
            @(posedge reloj); #2;
            reset = 1'b1;
            run_op(sel, va);
        end

        repeat (3) @(posedge reloj);
        chk("cola_vacia", 0, sb0.size(), 0);
        chk("cola_vacia", 1, sb1.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
`default_nettype wire
